rptr_empty: RTL and testbench

Read-domain pointer and empty-flag generator for the asynchronous FIFO, the counterpart of the write-side pointer/full logic. It holds the binary read address and the Gray-coded read pointer exported to the write domain. It raises a registered empty flag by comparing its next Gray pointer against the write pointer already synchronized into the read clock domain. It also provides a conservative occupancy count, a sticky underflow flag and an optional almost-empty flag.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/rptr_empty_if.sv | 46 ++++
 rtl/gray_to_bin.sv | 18 +
 rtl/rptr_empty.sv | 89 ++++++++
 tb/tb_rptr_empty.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default address width, pointer type
// and Gray/binary conversion helpers used by both the read and write sides.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return {1'b0, bin[FIFO_ADDR_WIDTH:1]} ^ bin;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int i = 1; i <= FIFO_ADDR_WIDTH; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-domain bundle between the read pointer block and its user.
// The almost-empty signal exists only when RPTR_ALMOST_EMPTY_EN is defined.
interface rptr_empty_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

    logic                  i_rinc;
    logic [ADDR_WIDTH:0]   i_rq2_wptr;
    logic                  o_rempty;
    logic [ADDR_WIDTH:0]   o_rptr;
    logic [ADDR_WIDTH-1:0] o_raddr;
    logic [ADDR_WIDTH:0]   o_rcount;
    logic                  o_runderflow;
`ifdef RPTR_ALMOST_EMPTY_EN
    logic                  o_ralmost_empty;
`endif

    modport master (
        output i_rinc,
        output i_rq2_wptr,
        input  o_rempty,
        input  o_rptr,
        input  o_raddr,
        input  o_rcount,
`ifdef RPTR_ALMOST_EMPTY_EN
        input  o_ralmost_empty,
`endif
        input  o_runderflow
    );

    modport slave (
        input  i_rinc,
        input  i_rq2_wptr,
        output o_rempty,
        output o_rptr,
        output o_raddr,
        output o_rcount,
`ifdef RPTR_ALMOST_EMPTY_EN
        output o_ralmost_empty,
`endif
        output o_runderflow
    );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // XOR-prefix from the MSB downwards
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty flag, occupancy count and sticky underflow.
// Optional almost-empty flag is built when RPTR_ALMOST_EMPTY_EN is defined.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH          = FIFO_ADDR_WIDTH,
    parameter int ALMOST_EMPTY_THRESH = 1
) (
    input  logic         i_rclk,
    input  logic         i_rrst,
    rptr_empty_if.slave  bus
);

    logic [ADDR_WIDTH:0] rbin_q,  rbin_d;
    logic [ADDR_WIDTH:0] rgray_q, rgray_d;
    logic [ADDR_WIDTH:0] rcount_q, rcount_d;
    logic [ADDR_WIDTH:0] wbin_s;
    logic                rempty_q, rempty_d;
    logic                runderflow_q, runderflow_d;
    logic                pop_s;

    if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > (2 ** ADDR_WIDTH) - 1) begin : g_bad_thresh
        $error("ALMOST_EMPTY_THRESH out of range");
    end

    gray_to_bin #(
        .WIDTH (ADDR_WIDTH + 1)
    ) u_wptr_g2b (
        .i_gray (bus.i_rq2_wptr),
        .o_bin  (wbin_s)
    );

    // Next pointer, empty and count; empty compares against the current
    // synchronized write pointer so a pop racing a new write stays non-empty.
    always_comb begin
        pop_s        = bus.i_rinc & ~rempty_q;
        rbin_d       = rbin_q + {{ADDR_WIDTH{1'b0}}, pop_s};
        rgray_d      = {1'b0, rbin_d[ADDR_WIDTH:1]} ^ rbin_d;
        rempty_d     = (rgray_d == bus.i_rq2_wptr);
        rcount_d     = wbin_s - rbin_d;
        runderflow_d = runderflow_q | (bus.i_rinc & rempty_q);
    end

    // Pointer, flag and count registers
    always_ff @(posedge i_rclk or posedge i_rrst) begin
        if (i_rrst) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            rcount_q     <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            rcount_q     <= rcount_d;
            rempty_q     <= rempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign bus.o_raddr      = rbin_q[ADDR_WIDTH-1:0];
    assign bus.o_rptr       = rgray_q;
    assign bus.o_rempty     = rempty_q;
    assign bus.o_rcount     = rcount_q;
    assign bus.o_runderflow = runderflow_q;

`ifdef RPTR_ALMOST_EMPTY_EN
    localparam logic [ADDR_WIDTH:0] THRESH_C = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESH);

    logic ralmost_empty_q, ralmost_empty_d;

    // Almost-empty follows the same pessimistic next count
    always_comb begin
        ralmost_empty_d = (rcount_d <= THRESH_C);
    end

    // Almost-empty register
    always_ff @(posedge i_rclk or posedge i_rrst) begin
        if (i_rrst) begin
            ralmost_empty_q <= 1'b1;
        end else begin
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign bus.o_ralmost_empty = ralmost_empty_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Randomized and directed checks of rptr_empty against a pointer-count model.
module tb_rptr_empty;

    localparam int AW  = 3;
    localparam int MOD = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    // Reference model: plain integer read/write counts modulo 2**(AW+1)
    int   m_rd;
    int   m_wr;
    bit   m_empty;
    bit   m_under;
    int   m_count;
    bit   m_almost;
    bit   m_pop;
    logic [AW:0] prev_rptr;

    rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

    rptr_empty #(
        .ADDR_WIDTH          (AW),
        .ALMOST_EMPTY_THRESH (1)
    ) dut (
        .i_rclk (clk),
        .i_rrst (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] gray_of(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_empty = 1'b1; m_under = 1'b0; m_count = 0; m_almost = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_empty"}, 32'(bus.o_rempty),     32'(m_empty));
        check_eq({tag, "_rptr"},  32'(bus.o_rptr),       32'(gray_of(m_rd)));
        check_eq({tag, "_raddr"}, 32'(bus.o_raddr),      32'(m_rd % 8));
        check_eq({tag, "_count"}, 32'(bus.o_rcount),     32'(m_count));
        check_eq({tag, "_under"}, 32'(bus.o_runderflow), 32'(m_under));
`ifdef RPTR_ALMOST_EMPTY_EN
        check_eq({tag, "_almost"}, 32'(bus.o_ralmost_empty), 32'(m_almost));
`endif
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge
    task automatic cyc(input bit rinc, input string tag);
        bus.i_rinc     = rinc;
        bus.i_rq2_wptr = gray_of(m_wr);
        prev_rptr      = bus.o_rptr;
        @(posedge clk);
        m_pop = rinc && !m_empty;
        if (rinc && m_empty) m_under = 1'b1;
        if (m_pop) m_rd = (m_rd + 1) % MOD;
        m_empty  = (m_rd == m_wr);
        m_count  = (m_wr - m_rd + MOD) % MOD;
        m_almost = (m_count <= 1);
        @(negedge clk);
        check_all(tag);
        check_eq({tag, "_gray1"}, 32'($countones(prev_rptr ^ bus.o_rptr)), 32'(m_pop ? 1 : 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            bus.i_rinc     = 1'($urandom_range(0, 1));
            bus.i_rq2_wptr = 4'($urandom_range(0, 15));
            @(negedge clk);
            check_all("reset");
        end
        m_wr = 0;
        bus.i_rinc     = 1'b0;
        bus.i_rq2_wptr = gray_of(m_wr);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; m_wr = 0; m_pop = 1'b0;
        bus.i_rinc = 1'b0; bus.i_rq2_wptr = '0;
        prev_rptr = '0;
        @(negedge clk);
        do_reset();

        // Fill to 3 then drain
        m_wr = 3;
        cyc(1'b0, "fill");
        check_eq("fill_count3", 32'(bus.o_rcount), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b1, "drain");
        check_eq("drain_rptr", 32'(bus.o_rptr), 32'b0010);
        check_eq("drain_empty", 32'(bus.o_rempty), 32'd1);

        // Underflow while empty, then sticky
        cyc(1'b1, "under");
        check_eq("under_raddr", 32'(bus.o_raddr), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, "under_hold");

        // Wrap: write pointer walks all codes while reading continuously
        for (int i = 0; i < 18; i++) begin
            m_wr = (m_wr + 1) % MOD;
            cyc(1'b1, "wrap");
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, "wrap_drain");

        // Simultaneous last-word pop and write-pointer advance 5 -> 6
        do_reset();
        m_wr = 5;
        cyc(1'b0, "sim_fill");
        for (int i = 0; i < 4; i++) cyc(1'b1, "sim_pop");
        check_eq("sim_count1", 32'(bus.o_rcount), 32'd1);
        m_wr = 6;
        cyc(1'b1, "sim");
        check_eq("sim_empty0", 32'(bus.o_rempty), 32'd0);
        check_eq("sim_count", 32'(bus.o_rcount), 32'd1);

        // Almost-empty drain 3 -> 2 -> 1 then asynchronous reset mid-drain
        do_reset();
        m_wr = 3;
        cyc(1'b0, "ae_fill");
        cyc(1'b1, "ae_2");
        cyc(1'b1, "ae_1");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        do_reset();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 2) != 0 && ((m_wr - m_rd + MOD) % MOD) < 8)
                    m_wr = (m_wr + 1) % MOD;
                cyc(1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
